// File: rtl/lcd_mono_pic_writer_if.sv
// Byte-stream and bitmap-ROM signals between the picture writer, its SPI byte
// writer and the row ROM.
interface lcd_mono_pic_writer_if;
  logic [8:0]   show_pic_data;
  logic         en_write_show_pic;
  logic         wr_done;
  logic [8:0]   rom_addr;
  logic [239:0] rom_q;

  modport master (
    output show_pic_data, en_write_show_pic, rom_addr,
    input  wr_done, rom_q
  );

  modport slave (
    input  show_pic_data, en_write_show_pic, rom_addr,
    output wr_done, rom_q
  );
endinterface

// File: rtl/lcd_mono_pic_writer.sv
// Draws a 1-bit-per-pixel bitmap from a row ROM into an LCD window: issues the
// 2A/2B/2C window commands, then two RGB565 bytes per pixel, one byte per wr_done.
module lcd_mono_pic_writer #(
  parameter int unsigned START_X  = 0,
  parameter int unsigned START_Y  = 0,
  parameter int unsigned PIC_W    = 240,
  parameter int unsigned PIC_H    = 240,
  parameter logic [15:0] FG_COLOR = 16'hFFFF,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         show_pic_flag,
  input  logic         wr_done,
  input  logic [239:0] rom_q,
  output logic [8:0]   rom_addr,
  output logic [8:0]   show_pic_data,
  output logic         en_write_show_pic,
  output logic         busy,
  output logic         pic_done
);

  localparam logic [15:0] XS       = 16'(START_X);
  localparam logic [15:0] XE       = 16'(START_X + PIC_W - 1);
  localparam logic [15:0] YS       = 16'(START_Y);
  localparam logic [15:0] YE       = 16'(START_Y + PIC_H - 1);
  localparam logic [7:0]  COL_LAST = 8'(PIC_W - 1);
  localparam logic [8:0]  ROW_LAST = 9'(PIC_H - 1);
  localparam logic [3:0]  CMD_LAST = 4'd10;

  typedef enum logic [2:0] {IDLE, CMD, ROW_LD, PIX_HI, PIX_LO, DONE} state_t;

  state_t         state_q, state_d;
  logic           wait_q, wait_d;       // second phase of a state: waiting for wr_done / ROM
  logic [3:0]     cmd_idx_q, cmd_idx_d;
  logic [8:0]     row_q, row_d;
  logic [7:0]     col_q, col_d;
  logic [239:0]   row_reg_q, row_reg_d;
  logic [8:0]     rom_addr_d, data_d;
  logic           strobe_d, busy_d, done_d;
  logic [7:0]     bit_idx;
  logic [15:0]    colour;

  function automatic logic [8:0] cmd_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    cmd_byte = {1'b0, 8'h2A};
      4'd1:    cmd_byte = {1'b1, XS[15:8]};
      4'd2:    cmd_byte = {1'b1, XS[7:0]};
      4'd3:    cmd_byte = {1'b1, XE[15:8]};
      4'd4:    cmd_byte = {1'b1, XE[7:0]};
      4'd5:    cmd_byte = {1'b0, 8'h2B};
      4'd6:    cmd_byte = {1'b1, YS[15:8]};
      4'd7:    cmd_byte = {1'b1, YS[7:0]};
      4'd8:    cmd_byte = {1'b1, YE[15:8]};
      4'd9:    cmd_byte = {1'b1, YE[7:0]};
      4'd10:   cmd_byte = {1'b0, 8'h2C};
      default: cmd_byte = 9'h000;
    endcase
  endfunction

  // Column 0 sits in the MSB of the ROM row.
  assign bit_idx = 8'd239 - col_q;
  assign colour  = row_reg_q[bit_idx] ? FG_COLOR : BG_COLOR;

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case can infer a latch.
    state_d    = state_q;
    wait_d     = wait_q;
    cmd_idx_d  = cmd_idx_q;
    row_d      = row_q;
    col_d      = col_q;
    row_reg_d  = row_reg_q;
    rom_addr_d = rom_addr;
    data_d     = show_pic_data;
    strobe_d   = 1'b0;
    busy_d     = busy;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (show_pic_flag) begin
          state_d   = CMD;
          busy_d    = 1'b1;
          wait_d    = 1'b0;
          cmd_idx_d = 4'd0;
        end
      end
      CMD: begin
        if (!wait_q) begin
          data_d   = cmd_byte(cmd_idx_q);
          strobe_d = 1'b1;
          wait_d   = 1'b1;
        end else if (wr_done) begin
          wait_d = 1'b0;
          if (cmd_idx_q == CMD_LAST) begin
            state_d = ROW_LD;
            row_d   = 9'd0;
            col_d   = 8'd0;
          end else begin
            cmd_idx_d = cmd_idx_q + 4'd1;
          end
        end
      end
      ROW_LD: begin
        if (!wait_q) begin
          rom_addr_d = row_q;
          wait_d     = 1'b1;
        end else begin
          row_reg_d = rom_q;
          wait_d    = 1'b0;
          state_d   = PIX_HI;
        end
      end
      PIX_HI: begin
        if (!wait_q) begin
          data_d   = {1'b1, colour[15:8]};
          strobe_d = 1'b1;
          wait_d   = 1'b1;
        end else if (wr_done) begin
          wait_d  = 1'b0;
          state_d = PIX_LO;
        end
      end
      PIX_LO: begin
        if (!wait_q) begin
          data_d   = {1'b1, colour[7:0]};
          strobe_d = 1'b1;
          wait_d   = 1'b1;
        end else if (wr_done) begin
          wait_d = 1'b0;
          if (col_q < COL_LAST) begin
            col_d   = col_q + 8'd1;
            state_d = PIX_HI;
          end else begin
            col_d = 8'd0;
            if (row_q < ROW_LAST) begin
              row_d   = row_q + 9'd1;
              state_d = ROW_LD;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; all next-state
  // logic lives in the always_comb above.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q           <= IDLE;
      wait_q            <= 1'b0;
      cmd_idx_q         <= 4'd0;
      row_q             <= 9'd0;
      col_q             <= 8'd0;
      row_reg_q         <= '0;
      rom_addr          <= 9'd0;
      show_pic_data     <= 9'd0;
      en_write_show_pic <= 1'b0;
      busy              <= 1'b0;
      pic_done          <= 1'b0;
    end else begin
      state_q           <= state_d;
      wait_q            <= wait_d;
      cmd_idx_q         <= cmd_idx_d;
      row_q             <= row_d;
      col_q             <= col_d;
      row_reg_q         <= row_reg_d;
      rom_addr          <= rom_addr_d;
      show_pic_data     <= data_d;
      en_write_show_pic <= strobe_d;
      busy              <= busy_d;
      pic_done          <= done_d;
    end
  end

endmodule

// File: tb/tb_lcd_mono_pic_writer.sv
// Scoreboard bench: a default-size writer (command stream, mid-frame reset) and
// a 4x2 writer (full frames, random SPI latency, stray wr_done, back-to-back frames).
module tb_lcd_mono_pic_writer;

  localparam logic [9:0] MARK = 10'h200;  // queue entry standing for a pic_done pulse

  logic sys_clk, sys_rst_n;
  logic flag_a, flag_b, busy_a, busy_b, done_a, done_b;
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt_b = 0;
  int   spur_b_req = 0;
  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];

  logic [9:0] cmd_a [11] = '{10'h02A, 10'h100, 10'h100, 10'h100, 10'h1EF, 10'h02B,
                             10'h100, 10'h100, 10'h100, 10'h1EF, 10'h02C};
  // START_X=10, START_Y=300, 4x2: XS=000A XE=000D YS=012C YE=012D
  logic [9:0] cmd_b [11] = '{10'h02A, 10'h100, 10'h10A, 10'h100, 10'h10D, 10'h02B,
                             10'h101, 10'h12C, 10'h101, 10'h12D, 10'h02C};
  logic [9:0] pix_b [16] = '{10'h1FF, 10'h1FF, 10'h100, 10'h100, 10'h1FF, 10'h1FF, 10'h100, 10'h100,
                             10'h100, 10'h100, 10'h1FF, 10'h1FF, 10'h1FF, 10'h1FF, 10'h100, 10'h100};

  lcd_mono_pic_writer_if bus_a ();
  lcd_mono_pic_writer_if bus_b ();

  lcd_mono_pic_writer dut_a (
    .sys_clk           (sys_clk),
    .sys_rst_n         (sys_rst_n),
    .show_pic_flag     (flag_a),
    .wr_done           (bus_a.wr_done),
    .rom_q             (bus_a.rom_q),
    .rom_addr          (bus_a.rom_addr),
    .show_pic_data     (bus_a.show_pic_data),
    .en_write_show_pic (bus_a.en_write_show_pic),
    .busy              (busy_a),
    .pic_done          (done_a)
  );

  lcd_mono_pic_writer #(.START_X(10), .START_Y(300), .PIC_W(4), .PIC_H(2)) dut_b (
    .sys_clk           (sys_clk),
    .sys_rst_n         (sys_rst_n),
    .show_pic_flag     (flag_b),
    .wr_done           (bus_b.wr_done),
    .rom_q             (bus_b.rom_q),
    .rom_addr          (bus_b.rom_addr),
    .show_pic_data     (bus_b.show_pic_data),
    .en_write_show_pic (bus_b.en_write_show_pic),
    .busy              (busy_b),
    .pic_done          (done_b)
  );

  // Pattern ROM for the default-size writer: pixel c of row r is set when (7c+r)%5 < 2.
  function automatic logic [239:0] row_a(input logic [8:0] r);
    logic [239:0] v;
    for (int c = 0; c < 240; c++) v[239 - c] = (((c * 7) + int'(r)) % 5) < 2;
    return v;
  endfunction

  assign bus_a.rom_q = row_a(bus_a.rom_addr);
  assign bus_b.rom_q = (bus_b.rom_addr == 9'd0) ? {4'b1010, 236'd0} :
                       (bus_b.rom_addr == 9'd1) ? {4'b0110, 236'd0} : '0;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  // SPI writer for the default-size writer: wr_done 16 cycles after every strobe.
  initial begin : spi_a
    bus_a.wr_done = 1'b0;
    forever begin
      @(posedge sys_clk); #2;
      bus_a.wr_done = 1'b0;
      if (sys_rst_n && bus_a.en_write_show_pic) begin
        repeat (16) @(posedge sys_clk);
        #2 bus_a.wr_done = 1'b1;
      end
    end
  end

  // SPI writer for the 4x2 writer: latency 1..40; after the wr_done that ends a row
  // (2C byte or row-0 last byte) wr_done stays high through both ROW_LD cycles.
  initial begin : spi_b
    int lat;
    int n_b;
    int spur_done;
    n_b = 0;
    spur_done = 0;
    bus_b.wr_done = 1'b0;
    forever begin
      @(posedge sys_clk); #2;
      bus_b.wr_done = 1'b0;
      if (!sys_rst_n) begin
        n_b = 0;
      end else if (bus_b.en_write_show_pic) begin
        lat = int'($urandom_range(40, 1));
        repeat (lat) @(posedge sys_clk);
        #2 bus_b.wr_done = 1'b1;
        if ((n_b % 27) == 10 || (n_b % 27) == 18) repeat (2) @(posedge sys_clk);
        n_b++;
      end else if (spur_b_req != spur_done) begin
        bus_b.wr_done = 1'b1;
        spur_done++;
      end
    end
  end

  // Monitor: pops the scoreboards on every strobe / pic_done, checks hold and handshake rules.
  initial begin : monitor
    logic       prev_rst, pend_a, pend_b;
    logic [8:0] held_a, held_b;
    logic [9:0] e;
    prev_rst = 1'b1;
    pend_a   = 1'b0;
    pend_b   = 1'b0;
    held_a   = '0;
    held_b   = '0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        if (prev_rst) begin
          check("rst_strobe_a", 32'(bus_a.en_write_show_pic), 0);
          check("rst_data_a",   32'(bus_a.show_pic_data), 0);
          check("rst_addr_a",   32'(bus_a.rom_addr), 0);
          check("rst_busy_a",   32'(busy_a), 0);
          check("rst_done_a",   32'(done_a), 0);
          check("rst_strobe_b", 32'(bus_b.en_write_show_pic), 0);
          check("rst_data_b",   32'(bus_b.show_pic_data), 0);
          check("rst_busy_b",   32'(busy_b), 0);
        end
        pend_a = 1'b0;
        pend_b = 1'b0;
      end else begin
        if (done_a) begin
          if (exp_a.size() == 0) check("extra_pic_done_a", 32'(done_a), 0);
          else begin e = exp_a.pop_front(); check("pic_done_a", 32'({done_a, 9'd0}), 32'(e)); end
        end
        if (bus_a.en_write_show_pic) begin
          check("strobe_on_wr_done_a", 32'(bus_a.wr_done), 0);
          check("busy_at_strobe_a", 32'(busy_a), 1);
          if (pend_a) check("strobe_before_wr_done_a", 32'(bus_a.en_write_show_pic), 0);
          if (exp_a.size() == 0) check("extra_strobe_a", 32'(bus_a.en_write_show_pic), 0);
          else begin e = exp_a.pop_front(); check("byte_a", 32'(bus_a.show_pic_data), 32'(e)); end
          pend_a = 1'b1;
          held_a = bus_a.show_pic_data;
        end else if (pend_a) begin
          check("data_hold_a", 32'(bus_a.show_pic_data), 32'(held_a));
          if (bus_a.wr_done) pend_a = 1'b0;
        end

        if (done_b) begin
          done_cnt_b++;
          if (exp_b.size() == 0) check("extra_pic_done_b", 32'(done_b), 0);
          else begin e = exp_b.pop_front(); check("pic_done_b", 32'({done_b, 9'd0}), 32'(e)); end
        end
        if (bus_b.en_write_show_pic) begin
          check("strobe_on_wr_done_b", 32'(bus_b.wr_done), 0);
          check("busy_at_strobe_b", 32'(busy_b), 1);
          if (pend_b) check("strobe_before_wr_done_b", 32'(bus_b.en_write_show_pic), 0);
          if (exp_b.size() == 0) check("extra_strobe_b", 32'(bus_b.en_write_show_pic), 0);
          else begin e = exp_b.pop_front(); check("byte_b", 32'(bus_b.show_pic_data), 32'(e)); end
          pend_b = 1'b1;
          held_b = bus_b.show_pic_data;
        end else if (pend_b) begin
          check("data_hold_b", 32'(bus_b.show_pic_data), 32'(held_b));
          if (bus_b.wr_done) pend_b = 1'b0;
        end
      end
      prev_rst = sys_rst_n;
    end
  end

  task automatic wait_drain_a(input int budget);
    int n = 0;
    while (exp_a.size() != 0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check("drain_a", 32'(exp_a.size()), 0);
  endtask

  task automatic wait_pic_done_b(input int budget);
    int n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!done_b && n < budget);
    check("frame_done_b", 32'(done_b), 1);
  endtask

  task automatic push_frame_b();
    foreach (cmd_b[i]) exp_b.push_back(cmd_b[i]);
    foreach (pix_b[i]) exp_b.push_back(pix_b[i]);
    exp_b.push_back(MARK);
  endtask

  initial begin : main
    logic [239:0] r0;
    sys_rst_n = 1'b1;
    flag_a    = 1'b0;
    flag_b    = 1'b0;
    #1 sys_rst_n = 1'b0;
    repeat (5) @(negedge sys_clk);
    @(posedge sys_clk); #3 sys_rst_n = 1'b1;

    // Stray wr_done pulses while idle must not start anything.
    spur_b_req = 3;
    repeat (20) @(negedge sys_clk);
    check("idle_busy_a", 32'(busy_a), 0);
    check("idle_busy_b", 32'(busy_b), 0);

    // Default window: command stream, then pixels 0..99 and the high byte of pixel 100.
    r0 = row_a(9'd0);
    foreach (cmd_a[i]) exp_a.push_back(cmd_a[i]);
    for (int c = 0; c < 100; c++) begin
      exp_a.push_back(r0[239 - c] ? 10'h1FF : 10'h100);
      exp_a.push_back(r0[239 - c] ? 10'h1FF : 10'h100);
    end
    exp_a.push_back(r0[139] ? 10'h1FF : 10'h100);
    flag_a = 1'b1;
    @(negedge sys_clk);
    check("busy_rise_a", 32'(busy_a), 1);
    wait_drain_a(8000);

    // Reset in the middle of pixel 100; the draw restarts from 2A after release.
    repeat (3) @(negedge sys_clk);
    @(posedge sys_clk); #3 sys_rst_n = 1'b0;
    repeat (30) @(negedge sys_clk);
    foreach (cmd_a[i]) exp_a.push_back(cmd_a[i]);
    @(posedge sys_clk); #3 sys_rst_n = 1'b1;
    wait_drain_a(1000);
    @(posedge sys_clk); #3 sys_rst_n = 1'b0;
    flag_a = 1'b0;
    repeat (30) @(negedge sys_clk);
    @(posedge sys_clk); #3 sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    check("abort_busy_a", 32'(busy_a), 0);

    // 4x2 window: two frames back to back with the flag held, then flag dropped mid-frame.
    push_frame_b();
    push_frame_b();
    flag_b = 1'b1;
    wait_pic_done_b(5000);
    @(negedge sys_clk);
    check("busy_gap_b", 32'(busy_b), 0);
    @(negedge sys_clk);
    check("busy_restart_b", 32'(busy_b), 1);
    flag_b = 1'b0;
    wait_pic_done_b(5000);
    spur_b_req = 7;
    repeat (60) @(negedge sys_clk);
    check("stay_idle_b", 32'(busy_b), 0);
    check("left_over_a", 32'(exp_a.size()), 0);
    check("left_over_b", 32'(exp_b.size()), 0);
    check("frames_b", 32'(done_cnt_b), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
